// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a UART transmitter: producer writes land in a circular buffer,
// and a two-state launcher pops one byte per character and waits for the stop-bit tick.
module uart_tx_feeder #(
  parameter int DBIT   = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DBIT-1:0]   wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              tx_start,
  output logic [DBIT-1:0]   tx_din,
  input  logic              tx_done_tick,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic {IDLE, WAIT} state_t;

  logic [DBIT-1:0]   mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  state_t            state_q;
  logic              tx_start_q;
  logic [DBIT-1:0]   tx_din_q;
  logic              overflow_q;
  logic              push, pop;

  assign full     = (count_q == FULL_COUNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign tx_start = tx_start_q;
  assign tx_din   = tx_din_q;
  assign busy     = (state_q == WAIT);

  // Fullness is judged on the registered count, so a pop in the same cycle never rescues a write.
  always_comb begin
    push     = wr_en && !full;
    pop      = (state_q == IDLE) && !empty;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is left uncleared on reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_start_q <= 1'b0;
      tx_din_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= wr_en && full;
      case (state_q)
        IDLE: begin
          if (!empty) begin
            tx_din_q   <= mem_q[rd_ptr_q];
            tx_start_q <= 1'b1;
            state_q    <= WAIT;
          end else begin
            tx_start_q <= 1'b0;
          end
        end
        WAIT: begin
          tx_start_q <= 1'b0;
          if (tx_done_tick) begin
            state_q <= IDLE;
          end
        end
        default: begin
          tx_start_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: a table of single-cycle vectors followed by
// hand-written sequences for ordering, overflow, simultaneous push/pop, wrap and reset.
module tb_uart_tx_feeder;

  logic       clk = 1'b0;
  logic       reset, wr_en, tx_done_tick;
  logic [7:0] wr_data;
  logic       full, empty, overflow, tx_start, busy;
  logic [4:0] count;
  logic [7:0] tx_din;

  int         vec_cnt = 0;
  int         err_cnt = 0;
  int         ovf_seen = 0;
  logic [7:0] got[$];

  always #5 clk = ~clk;

  uart_tx_feeder #(.DBIT(8), .ADDR_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .tx_done_tick (tx_done_tick),
    .busy         (busy)
  );

  typedef struct {
    logic       rst, we;
    logic [7:0] wd;
    logic       done;
    logic       st;
    logic [7:0] din;
    logic       bsy;
    logic [4:0] cnt;
    logic       fl, em, ov;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the edge and log launches/overflows.
  task automatic cycle(input logic r, input logic we, input logic [7:0] wd, input logic done);
    reset = r; wr_en = we; wr_data = wd; tx_done_tick = done;
    @(posedge clk);
    #1;
    if (tx_start) got.push_back(tx_din);
    if (overflow) ovf_seen++;
  endtask

  task automatic wait_start(input int k, input string name);
    for (int n = 0; n < 40 && got.size() <= k; n++) cycle(1'b0, 1'b0, 8'h00, 1'b0);
    chk(name, (got.size() > k), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; tx_done_tick = 1'b0;

    //            rst we  wd     done st  din    bsy cnt fl em ov
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 8'hC3, 1'b0, 1'b1, 8'h3C, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hC3, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 8'hC3, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 8'h88, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < 15; i++) begin
      cycle(vecs[i].rst, vecs[i].we, vecs[i].wd, vecs[i].done);
      chk($sformatf("v%0d.tx_start", i), tx_start, vecs[i].st);
      chk($sformatf("v%0d.tx_din", i),   tx_din,   vecs[i].din);
      chk($sformatf("v%0d.busy", i),     busy,     vecs[i].bsy);
      chk($sformatf("v%0d.count", i),    count,    vecs[i].cnt);
      chk($sformatf("v%0d.full", i),     full,     vecs[i].fl);
      chk($sformatf("v%0d.empty", i),    empty,    vecs[i].em);
      chk($sformatf("v%0d.overflow", i), overflow, vecs[i].ov);
    end

    // Ordering: three bytes, each answered by a done tick about 10 cycles after launch.
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    got.delete();
    cycle(1'b0, 1'b1, 8'h01, 1'b0);
    cycle(1'b0, 1'b1, 8'h02, 1'b0);
    cycle(1'b0, 1'b1, 8'h03, 1'b0);
    for (int k = 0; k < 3; k++) begin
      wait_start(k, $sformatf("order.launch%0d", k));
      repeat (9) cycle(1'b0, 1'b0, 8'h00, 1'b0);
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
      chk($sformatf("order.idle_busy%0d", k), busy, 1'b0);
      chk($sformatf("order.idle_start%0d", k), tx_start, 1'b0);
      if (k < 2) begin
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        chk($sformatf("order.relaunch%0d", k), tx_start, 1'b1);
      end
    end
    repeat (5) cycle(1'b0, 1'b0, 8'h00, 1'b0);
    chk("order.pulses", got.size(), 3);
    for (int k = 0; k < 3 && k < got.size(); k++) chk($sformatf("order.byte%0d", k), got[k], k + 1);

    // Full/overflow: 18 back-to-back writes while the first character never completes.
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    got.delete();
    ovf_seen = 0;
    for (int i = 0; i < 18; i++) cycle(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
    chk("full.count", count, 16);
    chk("full.full", full, 1'b1);
    chk("full.empty", empty, 1'b0);
    chk("full.overflow", overflow, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    chk("full.overflow_clear", overflow, 1'b0);
    chk("full.ovf_pulses", ovf_seen, 1);
    for (int j = 0; j < 16; j++) begin
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
      cycle(1'b0, 1'b0, 8'h00, 1'b0);
    end
    chk("full.drained", got.size(), 17);
    for (int j = 0; j < 17 && j < got.size(); j++) chk($sformatf("full.byte%0d", j), got[j], 8'h40 + j);
    chk("full.count_end", count, 0);
    chk("full.empty_end", empty, 1'b1);

    // Simultaneous push and pop keeps the count steady.
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    got.delete();
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 8'(8'h60 + i), 1'b0);
    chk("simul.count5", count, 5);
    chk("simul.busy", busy, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    chk("simul.count_done", count, 5);
    chk("simul.idle", busy, 1'b0);
    cycle(1'b0, 1'b1, 8'h70, 1'b0);
    chk("simul.count_kept", count, 5);
    chk("simul.launch", tx_start, 1'b1);
    chk("simul.din", tx_din, 8'h61);

    // Wrap-around: 40 incrementing bytes through the 16-deep buffer with full-gated writes.
    begin
      int  nw = 0;
      bit  saw_full = 0;
      logic we;
      cycle(1'b1, 1'b0, 8'h00, 1'b0);
      got.delete();
      ovf_seen = 0;
      for (int n = 0; n < 400 && got.size() < 40; n++) begin
        we = (nw < 40) && !full;
        if (full) saw_full = 1;
        cycle(1'b0, we, 8'(nw), busy);
        if (we) nw++;
      end
      chk("wrap.count_out", got.size(), 40);
      for (int j = 0; j < 40 && j < got.size(); j++) chk($sformatf("wrap.byte%0d", j), got[j], j);
      chk("wrap.saw_full", saw_full, 1'b1);
      chk("wrap.no_overflow", ovf_seen, 0);
      chk("wrap.count_end", count, 0);
    end

    // Reset in WAIT with seven bytes queued.
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'(8'h90 + i), 1'b0);
    chk("rst.count7", count, 7);
    chk("rst.busy_before", busy, 1'b1);
    cycle(1'b1, 1'b1, 8'hEE, 1'b1);
    chk("rst.count", count, 0);
    chk("rst.empty", empty, 1'b1);
    chk("rst.full", full, 1'b0);
    chk("rst.busy", busy, 1'b0);
    chk("rst.tx_start", tx_start, 1'b0);
    chk("rst.tx_din", tx_din, 8'h00);
    got.delete();
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    repeat (4) cycle(1'b0, 1'b0, 8'h00, 1'b0);
    chk("rst.no_launch", got.size(), 0);
    chk("rst.count_after", count, 0);
    chk("rst.busy_after", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 Parameter DBIT, default 8: data bits per character; width of wr_data and tx_din.
REQ-002 Parameter ADDR_W, default 4: FIFO address width; depth shall be 2**ADDR_W (16 by default).
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port wr_en, input, 1: producer write strobe, one byte per asserted cycle.
REQ-006 Port wr_data, input, DBIT: byte written when wr_en is accepted.
REQ-007 Port full, output, 1: FIFO holds 2**ADDR_W entries.
REQ-008 Port empty, output, 1: FIFO holds 0 entries.
REQ-009 Port count, output, ADDR_W+1: current number of stored entries.
REQ-010 Port overflow, output, 1: one-cycle pulse when a write is dropped.
REQ-011 Port tx_start, output, 1: one-cycle launch pulse to the downstream UART transmitter.
REQ-012 Port tx_din, output, DBIT: byte to transmit; valid from the tx_start cycle until the next launch.
REQ-013 Port tx_done_tick, input, 1: one-cycle pulse from the transmitter when the stop bit ends.
REQ-014 Port busy, output, 1: high while a launched character is awaiting tx_done_tick.

Function
REQ-015 The FIFO shall be a circular buffer with write and read pointers of ADDR_W bits that wrap from 2**ADDR_W-1 to 0.
REQ-016 A write shall be accepted when wr_en=1 and full=0 at the clock edge, storing wr_data at the write pointer and advancing it.
REQ-017 A write with wr_en=1 and full=1 shall be dropped: no state change, and overflow=1 in the following cycle only.
REQ-018 full shall be judged before any same-cycle pop: a write while full is dropped even if a pop occurs that cycle.
REQ-019 count shall be +1 on accept only, -1 on pop only, and unchanged on simultaneous accept and pop.
REQ-020 full and empty shall be derived from count and shall never both be 1.
REQ-021 The control FSM shall have exactly two states, IDLE and WAIT.
REQ-022 IDLE with empty=0: on the edge, load tx_din with the head entry, advance the read pointer (pop), register tx_start=1 for exactly one cycle, and go to WAIT.
REQ-023 IDLE with empty=1: remain in IDLE; tx_start=0; tx_din holds its value.
REQ-024 WAIT: tx_start=0; on tx_done_tick=1 go to IDLE; otherwise remain.
REQ-025 tx_done_tick in IDLE shall be ignored.
REQ-026 busy shall be 1 exactly when the FSM is in WAIT.
REQ-027 Latency: a byte written on edge N into an empty FIFO in IDLE shall appear with tx_start=1 during the cycle after edge N+1.
REQ-028 Back-to-back: after tx_done_tick on edge M with FIFO non-empty, the next tx_start shall be high in the cycle after edge M+1. This gives one IDLE cycle between characters.
REQ-029 A write into an empty FIFO shall not bypass storage; each byte passes through the FIFO.
REQ-030 Bytes shall be delivered in write order with no loss or duplication, except drops under REQ-017.

Reset
REQ-031 With reset=1 at an edge: FSM goes to IDLE, pointers and count become 0, empty=1, full=0, tx_start=0, overflow=0, busy=0, tx_din=0.
REQ-032 reset shall override wr_en and tx_done_tick in the same cycle; FIFO contents need not be cleared.
REQ-033 Reset during WAIT shall abandon the in-flight character and discard all queued bytes; after reset, tx_start stays 0 until a new write.

Verification
REQ-034 Single byte: reset, write 8'hA5 into the empty FIFO -> tx_start pulses one cycle, two cycles after the write edge, with tx_din=8'hA5; busy=1 until tx_done_tick is injected; count returns to 0.
REQ-035 Order: write 8'h01, 8'h02, 8'h03 on consecutive cycles, then answer each tx_start with tx_done_tick 10 cycles later -> tx_din sequence is 01, 02, 03; exactly 3 tx_start pulses; each is preceded by one IDLE cycle after its done.
REQ-036 Full/overflow: hold tx_done_tick low after the first launch and write 18 bytes -> count=16, full=1, 1 overflow pulse; the 18th byte is dropped; the 17th is accepted only because the first pop freed a slot.
REQ-037 Simultaneous: with count=5 in WAIT, assert tx_done_tick, then write in the same cycle as the next pop -> count remains 5 across that edge.
REQ-038 Wrap-around: push and drain 40 incrementing bytes through the depth-16 FIFO -> output equals input and pointers wrap correctly.
REQ-039 Reset mid-operation: assert reset in WAIT with count=7 -> next cycle count=0, empty=1, busy=0, tx_start=0; a stray tx_done_tick afterwards causes no launch.
